// File: rtl/ex_mem_stage.sv
// Execute stage of the RV32I pipeline: forwarding, ALU, branch/jump resolution,
// and the EX/MEM pipeline register feeding the memory stage.
module ex_mem_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic            JalrE,
   input  logic [1:0]      ResultSrcE,
   input  logic [1:0]      MemStrobeE,
   input  logic [3:0]      ALUControlE,
   input  logic [2:0]      Funct3E,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [4:0]      RdE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [1:0]      MemStrobeM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [4:0]      RdM
);

   localparam int unsigned SHW = 5;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] write_data;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic [SHW-1:0]  shamt;
   logic            cond;
   logic            eq;
   logic            lt_s;
   logic            lt_u;

   // Forwarding muxes; the 10 path uses the current (pre-edge) ALUResultM
   always_comb begin
      src_a = RD1E;
      write_data = RD2E;
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   write_data = ResultW;
         2'b10:   write_data = ALUResultM;
         default: write_data = RD2E;
      endcase
   end

   assign src_b = ALUSrcE ? ImmExtE : write_data;
   assign shamt = src_b[SHW-1:0];

   // ALU
   always_comb begin
      alu_result = '0;
      case (ALUControlE)
         4'b0000: alu_result = src_a + src_b;
         4'b0001: alu_result = src_a - src_b;
         4'b0010: alu_result = src_a & src_b;
         4'b0011: alu_result = src_a | src_b;
         4'b0100: alu_result = src_a ^ src_b;
         4'b0101: alu_result = XLEN'($signed(src_a) < $signed(src_b));
         4'b0110: alu_result = XLEN'(src_a < src_b);
         4'b0111: alu_result = src_a << shamt;
         4'b1000: alu_result = src_a >> shamt;
         4'b1001: alu_result = XLEN'($signed(src_a) >>> shamt);
         4'b1010: alu_result = src_b;
         4'b1011: alu_result = PCE + src_b;
         default: alu_result = '0;
      endcase
   end

   // Branch condition compares forwarded operands, never the immediate
   assign eq   = (src_a == write_data);
   assign lt_s = ($signed(src_a) < $signed(write_data));
   assign lt_u = (src_a < write_data);

   always_comb begin
      cond = 1'b0;
      case (Funct3E)
         3'b000:  cond = eq;
         3'b001:  cond = ~eq;
         3'b100:  cond = lt_s;
         3'b101:  cond = ~lt_s;
         3'b110:  cond = lt_u;
         3'b111:  cond = ~lt_u;
         default: cond = 1'b0;
      endcase
   end

   assign PCSrcE    = JumpE | (BranchE & cond);
   assign PCTargetE = JalrE ? ((src_a + ImmExtE) & ~XLEN'(1)) : (PCE + ImmExtE);

   // EX/MEM pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
         MemStrobeM <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
         RdM        <= '0;
      end else begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         MemStrobeM <= MemStrobeE;
         ALUResultM <= alu_result;
         WriteDataM <= write_data;
         PCPlus4M   <= PCPlus4E;
         RdM        <= RdE;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: ALU ops, forwarding, branch/jump redirect,
// pipeline register capture, bubbles and asynchronous reset.
module tb_ex_mem_stage;

   logic        clk;
   logic        rst;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE;
   logic [1:0]  ResultSrcE, MemStrobeE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
   logic [4:0]  RdE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ResultW;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM, MemStrobeM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;

   int errors = 0;
   int checks = 0;

   ex_mem_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .JalrE(JalrE),
      .ResultSrcE(ResultSrcE), .MemStrobeE(MemStrobeE),
      .ALUControlE(ALUControlE), .Funct3E(Funct3E),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
      .PCPlus4E(PCPlus4E), .RdE(RdE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ResultSrcM(ResultSrcM), .MemStrobeM(MemStrobeM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M), .RdM(RdM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_e();
      RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0; JalrE = 0;
      ResultSrcE = 0; MemStrobeE = 0; ALUControlE = 0; Funct3E = 0;
      RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0; RdE = 0;
      ForwardAE = 0; ForwardBE = 0; ResultW = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input string tag, input logic [3:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk);
      clear_e();
      ALUControlE = ctrl; RD1E = a; RD2E = b; RegWriteE = 1;
      tick();
      check(tag, ALUResultM, exp);
   endtask

   task automatic branch(input string tag, input logic [2:0] f3, input logic br,
                         input logic [31:0] a, input logic [31:0] b, input logic exp);
      @(negedge clk);
      clear_e();
      BranchE = br; Funct3E = f3; RD1E = a; RD2E = b; PCE = 32'h100; ImmExtE = 32'h20;
      #1;
      check(tag, 32'(PCSrcE), 32'(exp));
   endtask

   initial begin
      clear_e();
      rst = 0;
      PCE = 32'h100; ImmExtE = 32'h20; RegWriteE = 1; RD1E = 5; RD2E = 7;
      #3;
      check("rst_alu", ALUResultM, 32'h0);
      check("rst_regwrite", 32'(RegWriteM), 32'h0);
      check("rst_pcplus4", PCPlus4M, 32'h0);
      check("rst_target_comb", PCTargetE, 32'h120);

      // release reset, first capture on next edge
      @(negedge clk);
      clear_e();
      rst = 1;
      RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 5'd3;
      tick();
      check("add_5_7", ALUResultM, 32'd12);
      check("add_regwrite", 32'(RegWriteM), 32'h1);
      check("add_rd", 32'(RdM), 32'h3);

      // async reset mid-cycle with live inputs
      #2 rst = 0;
      #1;
      check("async_rst_alu", ALUResultM, 32'h0);
      check("async_rst_rd", 32'(RdM), 32'h0);
      @(negedge clk);
      rst = 1;
      tick();
      check("post_rst_add", ALUResultM, 32'd12);

      alu_op("sub", 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE);
      alu_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_op("sra", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000);
      alu_op("srl", 4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000);
      alu_op("sll_33", 4'b0111, 32'd1, 32'd33, 32'd2);
      alu_op("and", 4'b0010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000);
      alu_op("or", 4'b0011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
      alu_op("xor", 4'b0100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
      alu_op("lui_pass", 4'b1010, 32'h1234, 32'hABCD_E000, 32'hABCD_E000);
      alu_op("ctrl_1100", 4'b1100, 32'd9, 32'd9, 32'h0);
      alu_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1);

      // AUIPC uses PCE as A
      @(negedge clk);
      clear_e();
      ALUControlE = 4'b1011; PCE = 32'h400; RD1E = 32'h77; ALUSrcE = 1; ImmExtE = 32'h1000;
      tick();
      check("auipc", ALUResultM, 32'h1400);

      // forwarding from own ALUResultM
      alu_op("fwd_setup", 4'b0000, 32'd60, 32'd40, 32'd100);
      @(negedge clk);
      clear_e();
      RD1E = 1; ForwardAE = 2'b10; ALUSrcE = 1; ImmExtE = 4;
      tick();
      check("fwd_a_mem", ALUResultM, 32'd104);

      @(negedge clk);
      clear_e();
      RD1E = 7; ForwardAE = 2'b11; ResultW = 32'd50; ALUSrcE = 1; ImmExtE = 1;
      tick();
      check("fwd_a_11", ALUResultM, 32'd8);

      // store with forwarded write data
      @(negedge clk);
      clear_e();
      MemWriteE = 1; MemStrobeE = 2'b10; ALUSrcE = 1; RD1E = 32'h200; ImmExtE = 8;
      RD2E = 32'd55; ForwardBE = 2'b01; ResultW = 32'd9;
      tick();
      check("sw_wdata", WriteDataM, 32'd9);
      check("sw_memwrite", 32'(MemWriteM), 32'h1);
      check("sw_addr", ALUResultM, 32'h208);
      check("sw_strobe", 32'(MemStrobeM), 32'h2);

      // bubble after the store
      @(negedge clk);
      clear_e();
      tick();
      check("bubble_memwrite", 32'(MemWriteM), 32'h0);
      check("bubble_regwrite", 32'(RegWriteM), 32'h0);
      check("bubble_wdata", WriteDataM, 32'h0);

      // branches
      branch("beq_taken", 3'b000, 1, 32'd5, 32'd5, 1);
      check("beq_target", PCTargetE, 32'h120);
      branch("bne_equal", 3'b001, 1, 32'd5, 32'd5, 0);
      branch("bltu_taken", 3'b110, 1, 32'd1, 32'hFFFF_FFFF, 1);
      branch("blt_signed", 3'b100, 1, 32'd1, 32'hFFFF_FFFF, 0);
      branch("bge_neg", 3'b101, 1, 32'hFFFF_FFFF, 32'd0, 0);
      branch("bgeu_taken", 3'b111, 1, 32'hFFFF_FFFF, 32'd0, 1);
      branch("f3_010", 3'b010, 1, 32'd5, 32'd5, 0);
      branch("no_branch", 3'b000, 0, 32'd5, 32'd5, 0);

      // JALR with forwarded base
      @(negedge clk);
      clear_e();
      JumpE = 1; JalrE = 1; RegWriteE = 1; ResultSrcE = 2'b10; RdE = 5'd1;
      RD1E = 32'h1000; ForwardAE = 2'b01; ResultW = 32'h1003;
      ImmExtE = 2; ALUSrcE = 1; PCE = 32'h40; PCPlus4E = 32'h44;
      #1;
      check("jalr_pcsrc", 32'(PCSrcE), 32'h1);
      check("jalr_target", PCTargetE, 32'h1004);
      tick();
      check("jalr_pcplus4", PCPlus4M, 32'h44);
      check("jalr_resultsrc", 32'(ResultSrcM), 32'h2);

      // x0 destination passes through unchanged
      @(negedge clk);
      clear_e();
      RegWriteE = 1; RdE = 5'd0; RD1E = 32'd3; RD2E = 32'd4;
      tick();
      check("rd0_regwrite", 32'(RegWriteM), 32'h1);
      check("rd0_alu", ALUResultM, 32'd7);

      // reset mid-sequence clears outputs immediately
      @(negedge clk);
      clear_e();
      RegWriteE = 1; MemWriteE = 1; PCPlus4E = 32'h88; RD1E = 32'd1; RD2E = 32'd2;
      tick();
      check("pre_rst_pcplus4", PCPlus4M, 32'h88);
      #2 rst = 0;
      #1;
      check("mid_rst_pcplus4", PCPlus4M, 32'h0);
      check("mid_rst_memwrite", 32'(MemWriteM), 32'h0);
      check("mid_rst_alu", ALUResultM, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
